// File: rtl/tff_updown_counter.sv
// ---------------------------------------------------------------------------
// tff_updown_counter
//
// Synchronous WIDTH-bit up/down counter built as a row of T flip-flop cells.
// Each cell toggles when its toggle enable is high; the enables come from
// the lower bits of the count and the direction, which gives a
// ripple-free synchronous counter. The counter can be cascaded by feeding
// tc of a lower stage into en of the next stage.
//
// Optional build macro:
//   TFF_COUNT_SAT_EN : when defined, the counter saturates at all-ones
//                      (counting up) and at zero (counting down) instead of
//                      wrapping. tc then means "sitting at the limit".
//
// Parameters:
//   WIDTH     counter width in bits (2..16)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset, clears the count
//   en        in   count enable, one step per clock while high
//   up        in   direction, 1 = increment, 0 = decrement
//   load      in   synchronous parallel load, wins over en
//   load_val  in   value captured on load
//   q         out  current count (registered)
//   qbar      out  bitwise complement of q
//   tc        out  terminal count (combinational)
// ---------------------------------------------------------------------------
module tff_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             at_max;
    logic             at_min;
    logic             at_limit;
    logic             run_up;
    logic             run_dn;

    assign at_max   = &count_q;
    assign at_min   = ~|count_q;
    assign at_limit = up ? at_max : at_min;

    // Toggle enables: bit i flips when every lower bit is 1 (counting up)
    // or every lower bit is 0 (counting down). run_up/run_dn carry the
    // running AND of the lower bits along the chain.
    always_comb begin
        toggle = '0;
        run_up = 1'b1;
        run_dn = 1'b1;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                toggle[i] = up ? run_up : run_dn;
                run_up    = run_up & count_q[i];
                run_dn    = run_dn & ~count_q[i];
            end
`ifdef TFF_COUNT_SAT_EN
            // At the limit in the current direction every cell holds.
            if (at_limit) begin
                toggle = '0;
            end
`endif
        end
    end

    always_comb begin
        count_d = count_q ^ toggle;
        if (load) begin
            count_d = load_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q    = count_q;
    // Derived from the register directly so it reads all ones during reset.
    assign qbar = ~count_q;
    // Same equation in both modes: in wrap mode it flags the step before a
    // wrap, in saturating mode it flags that the counter is pinned.
    assign tc   = en & ~load & at_limit;

endmodule
